// File: rtl/hamming_pkg.sv
// Shared definitions for the extended-Hamming SECDED datapath: parity sizing,
// codeword layout helpers and the per-word error classification.
package hamming_pkg;

  typedef enum logic [1:0] {
    ECC_CLEAN = 2'd0,
    ECC_SEC   = 2'd1,
    ECC_DED   = 2'd2
  } ecc_status_t;

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Smallest P such that P parity bits can address DATA_W+P positions plus "no error".
  function automatic int calc_p(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  // Hamming position (1-based) of data bit j: the (j+1)-th non-power-of-two position.
  function automatic int data_pos(input int j);
    int pos;
    int cnt;
    pos = 0;
    cnt = -1;
    while (cnt < j) begin
      pos++;
      if (!is_pow2(pos)) cnt++;
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_secded_decoder_if.sv
// Codeword-in / corrected-word-out streaming bundle; slave = decoder, master = source/sink.
interface hamming_secded_decoder_if
  import hamming_pkg::*;
#(
  parameter int DATA_W = 8
);
  localparam int P    = calc_p(DATA_W);
  localparam int CW_W = DATA_W + P + 1;

  logic              in_valid;
  logic              in_ready;
  logic [CW_W-1:0]   in_cw;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sec;
  logic              out_ded;
  logic [P-1:0]      out_syn;

  modport slave (
    input  in_valid, in_cw, out_ready,
    output in_ready, out_valid, out_data, out_sec, out_ded, out_syn
  );

  modport master (
    output in_valid, in_cw, out_ready,
    input  in_ready, out_valid, out_data, out_sec, out_ded, out_syn
  );
endinterface

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall parity of an extended-Hamming codeword;
// zero latency, no flow control (shared with the encoder side).
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int P      = calc_p(DATA_W),
  localparam int CW_W   = DATA_W + P + 1
) (
  input  logic [CW_W-1:0] cw,
  output logic [P-1:0]    syn,
  output logic            ov
);

  always_comb begin
    syn = '0;
    for (int i = 1; i <= DATA_W + P; i++) begin
      for (int k = 0; k < P; k++) begin
        if (((i >> k) & 1) == 1) syn[k] = syn[k] ^ cw[i-1];
      end
    end
    ov = ^cw;
  end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage SECDED decoder with saturating SEC/DED telemetry counters; latency 2 cycles,
// each stage advances when the next is empty or drains the same cycle, so out_ready=0 stalls back to in_ready.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hamming_secded_decoder_if.slave bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     sec_cnt,
  output logic [CNT_W-1:0]     ded_cnt
);

  localparam int P    = calc_p(DATA_W);
  localparam int CW_W = DATA_W + P + 1;
  localparam int N    = DATA_W + P;

  logic              s1_full_q, s1_full_d;
  logic [CW_W-1:0]   s1_cw_q, s1_cw_d;
  logic [P-1:0]      s1_syn_q, s1_syn_d;
  logic              s1_ov_q, s1_ov_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sec_q, out_sec_d;
  logic              out_ded_q, out_ded_d;
  logic [P-1:0]      out_syn_q, out_syn_d;
  logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0]  ded_cnt_q, ded_cnt_d;

  logic [P-1:0]      syn_w;
  logic              ov_w;
  logic              in_ready, in_fire, out_fire, s1_moves;
  logic              sec_inc, ded_inc;
  ecc_status_t       status;
  logic [CW_W-1:0]   flip_mask, cw_fix;
  logic [DATA_W-1:0] data_fix;

  hamming_syndrome #(.DATA_W(DATA_W)) u_syndrome (
    .cw  (bus.in_cw),
    .syn (syn_w),
    .ov  (ov_w)
  );

  // Classify the word held in S1; an odd-weight error pointing past the last position is uncorrectable.
  always_comb begin
    status    = ECC_CLEAN;
    flip_mask = '0;
    if (s1_syn_q == '0) begin
      status = s1_ov_q ? ECC_SEC : ECC_CLEAN;
    end else if (!s1_ov_q || int'(s1_syn_q) > N) begin
      status = ECC_DED;
    end else begin
      status = ECC_SEC;
      for (int i = 1; i <= N; i++) begin
        if (int'(s1_syn_q) == i) flip_mask[i-1] = 1'b1;
      end
    end
    cw_fix = s1_cw_q ^ flip_mask;
  end

  for (genvar j = 0; j < DATA_W; j++) begin : g_extract
    assign data_fix[j] = cw_fix[data_pos(j) - 1];
  end

  always_comb begin
    out_fire  = out_valid_q && bus.out_ready;
    s1_moves  = s1_full_q && (!out_valid_q || bus.out_ready);
    in_ready  = rst_n && (!s1_full_q || s1_moves);
    in_fire   = bus.in_valid && in_ready;

    s1_full_d = in_fire || (s1_full_q && !s1_moves);
    s1_cw_d   = in_fire ? bus.in_cw : s1_cw_q;
    s1_syn_d  = in_fire ? syn_w     : s1_syn_q;
    s1_ov_d   = in_fire ? ov_w      : s1_ov_q;

    out_valid_d = s1_moves || (out_valid_q && !bus.out_ready);
    out_data_d  = s1_moves ? data_fix               : out_data_q;
    out_sec_d   = s1_moves ? (status == ECC_SEC)    : out_sec_q;
    out_ded_d   = s1_moves ? (status == ECC_DED)    : out_ded_q;
    out_syn_d   = s1_moves ? s1_syn_q               : out_syn_q;

    // Clear wins over the old value but not over an event landing in the same cycle.
    sec_inc = out_fire && out_sec_q;
    ded_inc = out_fire && out_ded_q;
    if (cnt_clr)                             sec_cnt_d = CNT_W'(sec_inc);
    else if (sec_inc && (sec_cnt_q != '1))   sec_cnt_d = sec_cnt_q + CNT_W'(1);
    else                                     sec_cnt_d = sec_cnt_q;
    if (cnt_clr)                             ded_cnt_d = CNT_W'(ded_inc);
    else if (ded_inc && (ded_cnt_q != '1))   ded_cnt_d = ded_cnt_q + CNT_W'(1);
    else                                     ded_cnt_d = ded_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full_q   <= 1'b0;
      s1_cw_q     <= '0;
      s1_syn_q    <= '0;
      s1_ov_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sec_q   <= 1'b0;
      out_ded_q   <= 1'b0;
      out_syn_q   <= '0;
      sec_cnt_q   <= '0;
      ded_cnt_q   <= '0;
    end else begin
      s1_full_q   <= s1_full_d;
      s1_cw_q     <= s1_cw_d;
      s1_syn_q    <= s1_syn_d;
      s1_ov_q     <= s1_ov_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sec_q   <= out_sec_d;
      out_ded_q   <= out_ded_d;
      out_syn_q   <= out_syn_d;
      sec_cnt_q   <= sec_cnt_d;
      ded_cnt_q   <= ded_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sec   = out_sec_q;
  assign bus.out_ded   = out_ded_q;
  assign bus.out_syn   = out_syn_q;
  assign sec_cnt       = sec_cnt_q;
  assign ded_cnt       = ded_cnt_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Randomized stream against a position-arithmetic SECDED model, plus literal codeword cases.
module tb_hamming_secded_decoder;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [7:0] data;
    logic       sec;
    logic       ded;
    logic [3:0] syn;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic cnt_clr;
  logic [CNT_W-1:0] sec_cnt, ded_cnt;

  int n_checks = 0;
  int n_errors = 0;

  res_t exp_q[$];
  int   m_sec = 0;
  int   m_ded = 0;
  bit   hold_vld = 0;
  logic [13:0] hold_bits;

  hamming_secded_decoder_if #(.DATA_W(8)) bus ();

  hamming_secded_decoder #(.DATA_W(8), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .cnt_clr (cnt_clr),
    .sec_cnt (sec_cnt),
    .ded_cnt (ded_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Syndrome = XOR of the position numbers of all set bits (positions 1..12).
  function automatic res_t model(input logic [12:0] cw);
    res_t r;
    int s;
    int k;
    logic [12:0] c;
    bit ov;
    s = 0; k = 0; c = cw; ov = ^cw;
    for (int i = 1; i <= 12; i++) if (cw[i-1]) s = s ^ i;
    r.syn = 4'(s);
    r.sec = 1'b0;
    r.ded = 1'b0;
    if (s == 0) r.sec = ov;
    else if (ov && s <= 12) begin r.sec = 1'b1; c[s-1] = ~c[s-1]; end
    else r.ded = 1'b1;
    r.data = '0;
    for (int i = 1; i <= 12; i++) begin
      if ((i & (i - 1)) != 0) begin r.data[k] = c[i-1]; k++; end
    end
    return r;
  endfunction

  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [12:0] c;
    int k;
    int s;
    c = '0; k = 0; s = 0;
    for (int i = 1; i <= 12; i++) begin
      if ((i & (i - 1)) != 0) begin c[i-1] = d[k]; k++; end
    end
    for (int i = 1; i <= 12; i++) if (c[i-1]) s = s ^ i;
    for (int b = 0; b < 4; b++) c[(1 << b) - 1] = s[b];
    c[12] = ^c[11:0];
    return c;
  endfunction

  function automatic logic [12:0] gen_cw();
    logic [12:0] c;
    int e, a, b;
    c = encode(8'($urandom));
    e = int'($urandom_range(0, 9));
    a = int'($urandom_range(0, 12));
    b = (a + int'($urandom_range(1, 12))) % 13;
    if (e >= 4) c[a] = ~c[a];
    if (e == 7 || e == 8) c[b] = ~c[b];
    if (e == 9) c = 13'($urandom);
    return c;
  endfunction

  // Single compare process: scoreboard on handshakes, counter model, stall stability.
  always @(negedge clk) begin
    res_t e;
    bit si, di;
    if (!rst_n) begin
      exp_q.delete();
      m_sec = 0; m_ded = 0; hold_vld = 0;
    end else begin
      chk("sec_cnt", 32'(sec_cnt), m_sec);
      chk("ded_cnt", 32'(ded_cnt), m_ded);
      if (hold_vld) begin
        chk("hold_valid", 32'(bus.out_valid), 1);
        chk("hold_bits", 32'({bus.out_data, bus.out_sec, bus.out_ded, bus.out_syn}), 32'(hold_bits));
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_cw));
      si = 0; di = 0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL out_unexpected: got data 0x%0h, expected no word", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(e.data));
          chk("out_sec",  32'(bus.out_sec),  32'(e.sec));
          chk("out_ded",  32'(bus.out_ded),  32'(e.ded));
          chk("out_syn",  32'(bus.out_syn),  32'(e.syn));
          si = e.sec; di = e.ded;
        end
      end
      if (cnt_clr) begin m_sec = int'(si); m_ded = int'(di); end
      else begin
        if (si && m_sec < CNT_MAX) m_sec++;
        if (di && m_ded < CNT_MAX) m_ded++;
      end
      hold_vld  = bus.out_valid && !bus.out_ready;
      hold_bits = {bus.out_data, bus.out_sec, bus.out_ded, bus.out_syn};
    end
  end

  task automatic directed(input string nm, input logic [12:0] cw, input int d, input int s,
                          input int dd, input int syn);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_cw = cw;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(bus.out_valid), 1);
    chk({nm, "_data"},  32'(bus.out_data), d);
    chk({nm, "_sec"},   32'(bus.out_sec), s);
    chk({nm, "_ded"},   32'(bus.out_ded), dd);
    chk({nm, "_syn"},   32'(bus.out_syn), syn);
  endtask

  task automatic stream(input int n, input bit rnd);
    int sent, cyc, budget;
    bit acc;
    logic [12:0] cw;
    sent = 0; cyc = 0; budget = 20 * n + 50;
    cw = gen_cw();
    while (sent < n && cyc < budget) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin sent++; cw = gen_cw(); end
      bus.out_ready = rnd ? ($urandom_range(0, 9) < 7) : ((cyc % 2) == 0);
      cnt_clr = rnd && ($urandom_range(0, 19) == 0);
      if (!(bus.in_valid && !acc))
        bus.in_valid = (sent < n) && (!rnd || ($urandom_range(0, 9) < 7));
      if (!(bus.in_valid && !acc) || acc) bus.in_cw = cw;
    end
    bus.in_valid = 1'b0;
    cnt_clr = 1'b0;
    chk("stream_sent", sent, n);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    res_t r;
    logic [12:0] c;
    int b;
    rst_n = 1'b0; cnt_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_cw = '0; bus.out_ready = 1'b1;

    chk("model_enc_a5", 32'(encode(8'hA5)), 'h0A27);
    r = model(13'h0A07);
    chk("model_syn6", 32'(r.syn), 6);
    chk("model_fix", 32'(r.data), 'hA5);
    r = model(13'h0823);
    chk("model_ded", 32'(r.ded), 1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready",  32'(bus.in_ready), 0);
    chk("rst_out_data",  32'(bus.out_data), 0);
    chk("rst_out_sec",   32'(bus.out_sec), 0);
    chk("rst_out_ded",   32'(bus.out_ded), 0);
    chk("rst_out_syn",   32'(bus.out_syn), 0);
    chk("rst_sec_cnt",   32'(sec_cnt), 0);
    chk("rst_ded_cnt",   32'(ded_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);

    directed("clean",   13'h0A27, 'hA5, 0, 0, 0);
    directed("bit5",    13'h0A07, 'hA5, 1, 0, 6);
    directed("overall", 13'h1A27, 'hA5, 1, 0, 0);
    directed("double",  13'h0823, 'h84, 0, 1, 9);
    @(posedge clk);
    @(negedge clk);
    chk("dir_sec_cnt", 32'(sec_cnt), 2);
    chk("dir_ded_cnt", 32'(ded_cnt), 1);

    stream(8, 1'b0);
    drain();

    @(posedge clk); #1; cnt_clr = 1'b1;
    @(posedge clk); #1; cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      c = encode(8'($urandom));
      b = int'($urandom_range(0, 12));
      c[b] = ~c[b];
      bus.in_valid = 1'b1; bus.in_cw = c;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    drain();
    chk("sat_sec_cnt", 32'(sec_cnt), 3);
    chk("sat_ded_cnt", 32'(ded_cnt), 0);

    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_cw = encode(8'h3C) ^ 13'h0010;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; cnt_clr = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1; cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_coincident", 32'(sec_cnt), 1);
    @(posedge clk); #1; cnt_clr = 1'b1;
    @(posedge clk); #1; cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_alone", 32'(sec_cnt), 0);

    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_cw = encode(8'h5A);
    @(posedge clk); #1; bus.in_cw = encode(8'hC3);
    @(posedge clk); #1; bus.in_valid = 1'b0;
    chk("pre_rst_valid", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    chk("mid_rst_edge_valid", 32'(bus.out_valid), 0);
    rst_n = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", 32'(bus.in_ready), 1);
    chk("rst_release_valid", 32'(bus.out_valid), 0);

    stream(300, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1);
  end

endmodule
